// File: rtl/fpga_exit_status_blinker.sv
// Captures the first program exit and shows it on the board LED: steady on for a pass,
// or a repeating burst of exit_value[3:0] blinks (0 means 16) separated by an off gap for a failure.
module fpga_exit_status_blinker #(
  parameter int unsigned TICK_DIV  = 12500000,
  parameter int unsigned GAP_UNITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        status_led_o,
  output logic        exit_latched_o,
  output logic [31:0] exit_value_q_o,
  output logic        busy_o
);

  localparam int unsigned GapTicks = GAP_UNITS * TICK_DIV;
  localparam int unsigned CntW     = (GapTicks > 2) ? $clog2(GapTicks) : 1;

  localparam logic [CntW-1:0] UnitLast = CntW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapTicks - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPass = 3'd1;
  localparam logic [2:0] StOn   = 3'd2;
  localparam logic [2:0] StOff  = 3'd3;
  localparam logic [2:0] StGap  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] tick_q, tick_d;
  logic [4:0]      blink_q, blink_d;
  logic [31:0]     value_q, value_d;
  logic            latched_q, latched_d;
  logic            valid_q;
  logic            led_q, led_d;
  logic            capture_evt;

  // A zero nibble stands for sixteen blinks.
  function automatic logic [4:0] blinks_from_nibble(input logic [3:0] nib);
    return (nib == 4'd0) ? 5'd16 : {1'b0, nib};
  endfunction

  assign capture_evt = exit_valid_i && !valid_q && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    blink_d   = blink_q;
    value_d   = value_q;
    latched_d = latched_q;
    case (state_q)
      StIdle: begin
        if (capture_evt) begin
          value_d   = exit_value_i;
          latched_d = 1'b1;
          tick_d    = '0;
          blink_d   = blinks_from_nibble(exit_value_i[3:0]);
          state_d   = (exit_value_i == 32'd0) ? StPass : StOn;
        end
      end
      StPass: begin
        state_d = StPass;
      end
      StOn: begin
        if (tick_q == UnitLast) begin
          tick_d  = '0;
          state_d = StOff;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StOff: begin
        if (tick_q == UnitLast) begin
          tick_d  = '0;
          blink_d = blink_q - 5'd1;
          state_d = (blink_q == 5'd1) ? StGap : StOn;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StGap: begin
        if (tick_q == GapLast) begin
          tick_d  = '0;
          blink_d = blinks_from_nibble(value_q[3:0]);
          state_d = StOn;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        tick_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Registered LED tracks the state being entered so it is high exactly in PASS/ON cycles.
  assign led_d = (state_d == StPass) || (state_d == StOn);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tick_q    <= '0;
      blink_q   <= 5'd0;
      value_q   <= 32'd0;
      latched_q <= 1'b0;
      valid_q   <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      value_q   <= value_d;
      latched_q <= latched_d;
      valid_q   <= exit_valid_i;
      led_q     <= led_d;
    end
  end

  assign status_led_o   = led_q;
  assign exit_latched_o = latched_q;
  assign exit_value_q_o = value_q;
  assign busy_o         = (state_q == StOn) || (state_q == StOff) || (state_q == StGap);

endmodule

// File: tb/tb_fpga_exit_status_blinker.sv
// Randomized self-checking bench for fpga_exit_status_blinker with TICK_DIV=4, GAP_UNITS=4.
module tb_fpga_exit_status_blinker;

  localparam int unsigned TDiv = 4;
  localparam int unsigned Gap  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = 32'd0;
  logic        status_led_o;
  logic        exit_latched_o;
  logic [31:0] exit_value_q_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  fpga_exit_status_blinker #(
    .TICK_DIV (TDiv),
    .GAP_UNITS(Gap)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .exit_valid_i  (exit_valid_i),
    .exit_value_i  (exit_value_i),
    .status_led_o  (status_led_o),
    .exit_latched_o(exit_latched_o),
    .exit_value_q_o(exit_value_q_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: k is the cycle count after the capture edge (k=1 is the first cycle after it).
  function automatic int blinks_of(input logic [31:0] v);
    int n;
    n = int'(v[3:0]);
    return (n == 0) ? 16 : n;
  endfunction

  function automatic int period_of(input logic [31:0] v);
    return blinks_of(v) * 2 * TDiv + Gap * TDiv;
  endfunction

  function automatic logic exp_led(input logic [31:0] v, input int k);
    int p;
    if (v == 32'd0) return 1'b1;
    p = (k - 1) % period_of(v);
    if (p >= blinks_of(v) * 2 * TDiv) return 1'b0;
    return ((p / TDiv) % 2) == 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni       = 1'b0;
    exit_valid_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exit_valid_i = 1'($urandom);
      exit_value_i = $urandom;
      next_cycle();
      @(negedge clk_i);
      n_checks++;
      if ({status_led_o, exit_latched_o, busy_o, exit_value_q_o} !== 35'd0) begin
        $display("FAIL reset: led=%b latched=%b busy=%b value=%h required all zero",
                 status_led_o, exit_latched_o, busy_o, exit_value_q_o);
      end else n_pass++;
    end
    exit_valid_i = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk_i);
      n_checks++;
      if ({status_led_o, exit_latched_o, busy_o} !== 3'b000) begin
        $display("FAIL idle_after_reset: led=%b latched=%b busy=%b required 000",
                 status_led_o, exit_latched_o, busy_o);
      end else n_pass++;
    end
  endtask

  task automatic test_pass();
    apply_reset();
    exit_value_i = 32'd0;
    exit_valid_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      next_cycle();
      exit_valid_i = 1'($urandom);
      exit_value_i = $urandom;
      @(negedge clk_i);
      n_checks++;
      if ({status_led_o, exit_latched_o, busy_o} !== 3'b110 || exit_value_q_o !== 32'd0) begin
        $display("FAIL pass k=%0d: led=%b latched=%b busy=%b value=%h required 1 1 0 0",
                 k, status_led_o, exit_latched_o, busy_o, exit_value_q_o);
      end else n_pass++;
    end
  endtask

  // Capture v in the current cycle and compare the LED/busy pattern for ncyc cycles.
  task automatic test_fail_code(input logic [31:0] v, input int ncyc, input string name);
    apply_reset();
    exit_value_i = v;
    exit_valid_i = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      next_cycle();
      exit_valid_i = 1'b0;
      exit_value_i = $urandom;
      @(negedge clk_i);
      n_checks++;
      if (status_led_o !== exp_led(v, k) || busy_o !== (v != 32'd0) || exit_latched_o !== 1'b1)
      begin
        $display("FAIL %s k=%0d: led=%b busy=%b latched=%b required led=%b busy=%b latched=1",
                 name, k, status_led_o, busy_o, exit_latched_o, exp_led(v, k), (v != 32'd0));
      end else n_pass++;
    end
    n_checks++;
    if (exit_value_q_o !== v) begin
      $display("FAIL %s value: got %h required %h", name, exit_value_q_o, v);
    end else n_pass++;
  endtask

  task automatic test_sticky();
    logic [31:0] v = 32'd2;
    apply_reset();
    exit_value_i = v;
    exit_valid_i = 1'b1;
    for (int k = 1; k <= 2 * period_of(v); k++) begin
      next_cycle();
      exit_valid_i = (k >= 10 && k < 13) || (k >= 30 && k < 31);
      exit_value_i = exit_valid_i ? 32'd0 : $urandom;
      @(negedge clk_i);
      n_checks++;
      if (status_led_o !== exp_led(v, k) || exit_value_q_o !== v) begin
        $display("FAIL sticky k=%0d: led=%b value=%h required led=%b value=%h",
                 k, status_led_o, exit_value_q_o, exp_led(v, k), v);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_mid_on();
    logic [31:0] v = 32'd3;
    apply_reset();
    exit_value_i = v;
    exit_valid_i = 1'b1;
    // Second blink is on for k = 2*TDiv+1 .. 3*TDiv.
    for (int k = 1; k <= 2 * TDiv + 2; k++) begin
      next_cycle();
      exit_valid_i = 1'b0;
    end
    @(negedge clk_i);
    n_checks++;
    if (status_led_o !== 1'b1) begin
      $display("FAIL mid_on_precondition: led=%b required 1", status_led_o);
    end else n_pass++;
    #1 rst_ni = 1'b0;
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({status_led_o, exit_latched_o, busy_o} !== 3'b000 || exit_value_q_o !== 32'd0) begin
      $display("FAIL mid_on_reset: led=%b latched=%b busy=%b value=%h required 0 0 0 0",
               status_led_o, exit_latched_o, busy_o, exit_value_q_o);
    end else n_pass++;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk_i);
      n_checks++;
      if ({status_led_o, busy_o} !== 2'b00) begin
        $display("FAIL mid_on_no_resume: led=%b busy=%b required 00", status_led_o, busy_o);
      end else n_pass++;
    end
    next_cycle();
    v            = 32'd1;
    exit_value_i = v;
    exit_valid_i = 1'b1;
    for (int k = 1; k <= 2 * period_of(v); k++) begin
      next_cycle();
      exit_valid_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (status_led_o !== exp_led(v, k)) begin
        $display("FAIL mid_on_reblink k=%0d: led=%b required %b", k, status_led_o, exp_led(v, k));
      end else n_pass++;
    end
  endtask

  task automatic test_level_at_reset();
    logic [31:0] v = 32'd5;
    rst_ni       = 1'b0;
    exit_valid_i = 1'b1;
    exit_value_i = v;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({status_led_o, exit_latched_o} !== 2'b00) begin
      $display("FAIL level_release_cycle: led=%b latched=%b required 00",
               status_led_o, exit_latched_o);
    end else n_pass++;
    for (int k = 1; k <= period_of(v) + 4; k++) begin
      next_cycle();
      @(negedge clk_i);
      n_checks++;
      if (status_led_o !== exp_led(v, k) || exit_latched_o !== 1'b1 || exit_value_q_o !== v) begin
        $display("FAIL level_at_reset k=%0d: led=%b latched=%b value=%h required %b 1 %h",
                 k, status_led_o, exit_latched_o, exit_value_q_o, exp_led(v, k), v);
      end else n_pass++;
    end
    exit_valid_i = 1'b0;
  endtask

  task automatic test_random_codes();
    logic [31:0] v;
    for (int it = 0; it < 6; it++) begin
      v = $urandom;
      if (it == 0) v[3:0] = 4'd0;
      if (it == 1) v = 32'd7;
      apply_reset();
      exit_value_i = v;
      exit_valid_i = 1'b1;
      for (int k = 1; k <= period_of(v) + 12; k++) begin
        next_cycle();
        exit_valid_i = 1'($urandom);
        exit_value_i = $urandom;
        @(negedge clk_i);
        n_checks++;
        if (status_led_o !== exp_led(v, k) || busy_o !== 1'b1 || exit_value_q_o !== v) begin
          $display("FAIL random v=%h k=%0d: led=%b busy=%b value=%h required led=%b busy=1",
                   v, k, status_led_o, busy_o, exit_value_q_o, exp_led(v, k));
        end else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_code(32'd3, 2 * 40 + 5, "fail3");
    test_fail_code(32'h10, 144 + 20, "wrap16");
    test_sticky();
    test_reset_mid_on();
    test_level_at_reset();
    test_random_codes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
